program_sequencer: RTL

Fetch/execute controller for the 9-bit-instruction CPU inside `top_level`. It owns the program counter and runs the `start`/`halt` protocol. It sequences instruction-memory reads, latches the instruction register, and issues one commit strobe per instruction to the datapath. Performance counters expose cycle and retired-instruction counts to the bench.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/program_sequencer_if.sv | 42 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/program_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Sequencer state encoding lives here so the datapath can decode it too.
package cpu_pkg;

    localparam int INSTR_WIDTH = 9;
    localparam int OP_WIDTH    = 3;
    localparam int NUM_REGS    = 12;
    localparam int REG_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        DONE
    } seq_state_t;

    function automatic logic is_active(seq_state_t s);
        return (s == FETCH) || (s == LOAD) || (s == EXEC);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory and datapath bundle around the sequencer.
// master = sequencer side, slave = memory/decoder side.
interface program_sequencer_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9
) ();

    logic                   imem_rd;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   exec_en;
    logic                   stall;
    logic                   halt_req;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;

    modport master (
        output imem_rd,
        output imem_addr,
        output ir,
        output exec_en,
        input  imem_data,
        input  stall,
        input  halt_req,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        input  ir,
        input  exec_en,
        output imem_data,
        output stall,
        output halt_req,
        output branch_taken,
        output branch_target
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable; the count sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute controller: owns pc and ir, runs start/halt.
// Outputs are registered alongside the state they belong to.
module program_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    program_sequencer_if.master  bus,
    output logic                 halt,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    import cpu_pkg::*;

    seq_state_t             state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   start_q;
    logic                   imem_rd;
    logic                   exec_en;
    logic                   active;
    logic                   retire;

    assign active = is_active(state);
    assign retire = (state == EXEC) && !bus.stall;

    assign bus.imem_rd   = imem_rd;
    assign bus.imem_addr = pc;
    assign bus.ir        = ir;
    assign bus.exec_en   = exec_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            start_q <= 1'b0;
            imem_rd <= 1'b0;
            exec_en <= 1'b0;
            halt    <= 1'b0;
        end else begin
            start_q <= start;
            if (start) begin
                // abort from any state; ir is left as-is
                state   <= IDLE;
                pc      <= '0;
                imem_rd <= 1'b0;
                exec_en <= 1'b0;
                halt    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_q) begin
                            state   <= FETCH;
                            imem_rd <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state   <= LOAD;
                        imem_rd <= 1'b0;
                    end
                    LOAD: begin
                        ir      <= bus.imem_data;
                        state   <= EXEC;
                        exec_en <= 1'b1;
                    end
                    EXEC: begin
                        if (bus.stall) begin
                            state <= EXEC;
                        end else if (bus.halt_req) begin
                            state   <= DONE;
                            exec_en <= 1'b0;
                            halt    <= 1'b1;
                        end else begin
                            pc      <= bus.branch_taken ?
                                       bus.branch_target :
                                       pc + PC_WIDTH'(1);
                            state   <= FETCH;
                            exec_en <= 1'b0;
                            imem_rd <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state   <= IDLE;
                        imem_rd <= 1'b0;
                        exec_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_cycle_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .en   (active),
        .count(cycle_count)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_instr_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .en   (retire),
        .count(instr_count)
    );

endmodule
